// File: rtl/smpl_ser_tx.sv
// Left-justified stereo serializer: captures a sample pair on each trigger and
// shifts it out MSB-first on bclk/lrclk/sdata, flagging dropped triggers.
module smpl_ser_tx #(
    parameter int SAMPLE_W      = 16,
    parameter int BCLK_HALF_DIV = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                smpl_rate_trig,
    input  logic [SAMPLE_W-1:0] sample_l,
    input  logic [SAMPLE_W-1:0] sample_r,
    output logic                sample_ack,
    output logic                overrun,
    output logic                busy,
    output logic                bclk,
    output logic                lrclk,
    output logic                sdata
);

    localparam int HCW = (BCLK_HALF_DIV > 1) ? $clog2(BCLK_HALF_DIV) : 1;
    localparam int BCW = $clog2(SAMPLE_W);
    localparam logic [HCW-1:0] HALF_LAST = HCW'(BCLK_HALF_DIV - 1);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(SAMPLE_W - 1);

    typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

    state_t                  state, state_n;
    logic [HCW-1:0]          half_cnt, half_cnt_n;
    logic [BCW-1:0]          bit_cnt, bit_cnt_n;
    logic [2*SAMPLE_W-1:0]   sreg, sreg_n;
    logic                    bclk_n, ack_n, ovr_n;
    logic                    half_end, slot_end, frame_end;

    // Left and right samples share one shift register, so the MSB is always
    // the bit on the wire and it drains to zero by the end of the frame.
    assign sdata = sreg[2*SAMPLE_W-1];

    always_comb begin
        state_n    = state;
        half_cnt_n = half_cnt;
        bit_cnt_n  = bit_cnt;
        sreg_n     = sreg;
        bclk_n     = bclk;
        ack_n      = 1'b0;
        ovr_n      = 1'b0;

        half_end  = (state != IDLE) && (half_cnt == HALF_LAST);
        slot_end  = half_end && bclk;
        frame_end = slot_end && (state == RIGHT) && (bit_cnt == BIT_LAST);

        if (state != IDLE) begin
            if (half_end) begin
                half_cnt_n = '0;
                bclk_n     = ~bclk;
            end else begin
                half_cnt_n = half_cnt + 1'b1;
            end
            if (slot_end) begin
                sreg_n = {sreg[2*SAMPLE_W-2:0], 1'b0};
                if (bit_cnt == BIT_LAST) begin
                    bit_cnt_n = '0;
                    state_n   = (state == LEFT) ? RIGHT : IDLE;
                end else begin
                    bit_cnt_n = bit_cnt + 1'b1;
                end
            end
            if (smpl_rate_trig && !frame_end)
                ovr_n = 1'b1;
        end

        // A trigger on the final cycle of a frame chains straight into a new one.
        if (smpl_rate_trig && ((state == IDLE) || frame_end)) begin
            state_n    = LEFT;
            sreg_n     = {sample_l, sample_r};
            half_cnt_n = '0;
            bit_cnt_n  = '0;
            bclk_n     = 1'b0;
            ack_n      = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            half_cnt   <= '0;
            bit_cnt    <= '0;
            sreg       <= '0;
            bclk       <= 1'b0;
            lrclk      <= 1'b0;
            busy       <= 1'b0;
            sample_ack <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_n;
            half_cnt   <= half_cnt_n;
            bit_cnt    <= bit_cnt_n;
            sreg       <= sreg_n;
            bclk       <= bclk_n;
            lrclk      <= (state_n == RIGHT);
            busy       <= (state_n != IDLE);
            sample_ack <= ack_n;
            overrun    <= ovr_n;
        end
    end

endmodule

// File: tb/tb_smpl_ser_tx.sv
// Directed bench for smpl_ser_tx: a small instance (W=4, H=2) for timing corner
// cases and a default instance for full-width bit-exact frames.
module tb_smpl_ser_tx;

    logic clk = 1'b0;
    logic clk_en = 1'b0;
    logic reset = 1'b0;

    logic       s_trig = 1'b0;
    logic [3:0] s_l = '0, s_r = '0;
    logic       s_ack, s_ovr, s_busy, s_bclk, s_lr, s_sd;

    logic        d_trig = 1'b0;
    logic [15:0] d_l = '0, d_r = '0;
    logic        d_ack, d_ovr, d_busy, d_bclk, d_lr, d_sd;

    int checks = 0;
    int failures = 0;

    smpl_ser_tx #(.SAMPLE_W(4), .BCLK_HALF_DIV(2)) u_small (
        .clk(clk), .reset(reset), .smpl_rate_trig(s_trig),
        .sample_l(s_l), .sample_r(s_r), .sample_ack(s_ack), .overrun(s_ovr),
        .busy(s_busy), .bclk(s_bclk), .lrclk(s_lr), .sdata(s_sd)
    );

    smpl_ser_tx #(.SAMPLE_W(16), .BCLK_HALF_DIV(16)) u_dflt (
        .clk(clk), .reset(reset), .smpl_rate_trig(d_trig),
        .sample_l(d_l), .sample_r(d_r), .sample_ack(d_ack), .overrun(d_ovr),
        .busy(d_busy), .bclk(d_bclk), .lrclk(d_lr), .sdata(d_sd)
    );

    initial forever begin
        #5;
        if (clk_en) clk = ~clk;
    end

    // Issues a trigger with l/r, then observes ncyc cycles; cycle i is the one
    // after capture edge i-1+1. A second trigger (l2/r2) is driven in cycle t2.
    task automatic watch_small(input logic [3:0] l, input logic [3:0] r, input int ncyc,
                               input int t2, input logic [3:0] l2, input logic [3:0] r2,
                               output logic [15:0] bits, output logic [15:0] lrs,
                               output int nbits, output int busy_cnt, output int acks,
                               output int ovrs, output int ack_at, output int ovr_at,
                               output int idle_at);
        logic prev;
        bits = '0; lrs = '0; nbits = 0; busy_cnt = 0; acks = 0; ovrs = 0;
        ack_at = -1; ovr_at = -1; idle_at = -1;
        @(negedge clk);
        s_trig = 1'b1; s_l = l; s_r = r;
        prev = s_bclk;
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge clk);
            if (s_bclk && !prev) begin
                bits = {bits[14:0], s_sd};
                lrs  = {lrs[14:0], s_lr};
                nbits++;
            end
            prev = s_bclk;
            if (s_busy) busy_cnt++;
            else if (idle_at < 0) idle_at = i;
            if (s_ack) begin acks++; if (ack_at < 0) ack_at = i; end
            if (s_ovr) begin ovrs++; if (ovr_at < 0) ovr_at = i; end
            if (i == t2) begin
                s_trig = 1'b1; s_l = l2; s_r = r2;
            end else begin
                s_trig = 1'b0; s_l = ~l; s_r = ~r;
            end
        end
        s_trig = 1'b0;
    endtask

    task automatic watch_big(input logic [15:0] l, input logic [15:0] r, input int ncyc,
                             output logic [31:0] bits, output int nbits,
                             output int busy_cnt, output int acks, output int ovrs);
        logic prev;
        bits = '0; nbits = 0; busy_cnt = 0; acks = 0; ovrs = 0;
        @(negedge clk);
        d_trig = 1'b1; d_l = l; d_r = r;
        prev = d_bclk;
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge clk);
            d_trig = 1'b0; d_l = ~l; d_r = ~r;
            if (d_bclk && !prev) begin
                bits = {bits[30:0], d_sd};
                nbits++;
            end
            prev = d_bclk;
            if (d_busy) busy_cnt++;
            if (d_ack) acks++;
            if (d_ovr) ovrs++;
        end
    endtask

    task automatic test_reset;
        int bad = 0;
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({s_ack, s_ovr, s_busy, s_bclk, s_lr, s_sd} !== 6'b0) begin
            failures++;
            $display("FAIL reset_small outs=%b want=000000", {s_ack, s_ovr, s_busy, s_bclk, s_lr, s_sd});
        end
        checks++;
        if ({d_ack, d_ovr, d_busy, d_bclk, d_lr, d_sd} !== 6'b0) begin
            failures++;
            $display("FAIL reset_dflt outs=%b want=000000", {d_ack, d_ovr, d_busy, d_bclk, d_lr, d_sd});
        end
        clk_en = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ({s_ack, s_ovr, s_busy, s_bclk, s_lr, s_sd, d_ack, d_ovr, d_busy, d_bclk, d_lr, d_sd} !== 12'b0)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL idle_hold nonzero_cycles=%0d want=0", bad);
        end
    endtask

    task automatic test_single_frame;
        logic [15:0] bits, lrs;
        int nbits, busy_cnt, acks, ovrs, ack_at, ovr_at, idle_at;
        watch_small(4'hA, 4'h5, 40, -1, 4'h0, 4'h0, bits, lrs, nbits, busy_cnt, acks, ovrs, ack_at, ovr_at, idle_at);
        checks++;
        if (ack_at != 1 || acks != 1) begin
            failures++; $display("FAIL single_ack at=%0d count=%0d want at=1 count=1", ack_at, acks);
        end
        checks++;
        if (nbits != 8 || bits[7:0] !== 8'hA5) begin
            failures++; $display("FAIL single_data nbits=%0d bits=%h want 8/a5", nbits, bits[7:0]);
        end
        checks++;
        if (lrs[7:0] !== 8'h0F) begin
            failures++; $display("FAIL single_lrclk got=%b want=00001111", lrs[7:0]);
        end
        checks++;
        if (busy_cnt != 32 || idle_at != 33) begin
            failures++; $display("FAIL single_busy cycles=%0d idle_at=%0d want 32/33", busy_cnt, idle_at);
        end
        checks++;
        if (ovrs != 0) begin
            failures++; $display("FAIL single_overrun got=%0d want=0", ovrs);
        end
    endtask

    task automatic test_default_frames;
        logic [15:0] ramp [4] = '{16'h0001, 16'h8000, 16'h7FFF, 16'hFFFF};
        logic [31:0] bits;
        int nbits, busy_cnt, acks, ovrs;
        for (int k = 0; k < 4; k++) begin
            watch_big(ramp[k], ramp[3-k], 2082, bits, nbits, busy_cnt, acks, ovrs);
            checks++;
            if (nbits != 32 || bits !== {ramp[k], ramp[3-k]}) begin
                failures++;
                $display("FAIL dflt_data frame=%0d nbits=%0d got=%h want=%h", k, nbits, bits, {ramp[k], ramp[3-k]});
            end
            checks++;
            if (busy_cnt != 1024 || acks != 1 || ovrs != 0) begin
                failures++;
                $display("FAIL dflt_timing frame=%0d busy=%0d acks=%0d ovr=%0d want 1024/1/0", k, busy_cnt, acks, ovrs);
            end
        end
    endtask

    task automatic test_overrun;
        logic [15:0] bits, lrs;
        int nbits, busy_cnt, acks, ovrs, ack_at, ovr_at, idle_at;
        watch_small(4'hA, 4'h5, 40, 10, 4'h3, 4'hC, bits, lrs, nbits, busy_cnt, acks, ovrs, ack_at, ovr_at, idle_at);
        checks++;
        if (ovr_at != 11 || ovrs != 1) begin
            failures++; $display("FAIL overrun_pulse at=%0d count=%0d want at=11 count=1", ovr_at, ovrs);
        end
        checks++;
        if (bits[7:0] !== 8'hA5 || nbits != 8) begin
            failures++; $display("FAIL overrun_data bits=%h nbits=%0d want a5/8", bits[7:0], nbits);
        end
        checks++;
        if (acks != 1 || busy_cnt != 32) begin
            failures++; $display("FAIL overrun_ack acks=%0d busy=%0d want 1/32", acks, busy_cnt);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] bits, lrs;
        int nbits, busy_cnt, acks, ovrs, ack_at, ovr_at, idle_at;
        watch_small(4'hA, 4'h5, 70, 32, 4'h3, 4'hC, bits, lrs, nbits, busy_cnt, acks, ovrs, ack_at, ovr_at, idle_at);
        checks++;
        if (busy_cnt != 64 || idle_at != 65) begin
            failures++; $display("FAIL b2b_busy cycles=%0d idle_at=%0d want 64/65", busy_cnt, idle_at);
        end
        checks++;
        if (nbits != 16 || bits !== 16'hA53C) begin
            failures++; $display("FAIL b2b_data nbits=%0d bits=%h want 16/a53c", nbits, bits);
        end
        checks++;
        if (lrs !== 16'h0F0F) begin
            failures++; $display("FAIL b2b_lrclk got=%h want=0f0f", lrs);
        end
        checks++;
        if (acks != 2 || ovrs != 0) begin
            failures++; $display("FAIL b2b_flags acks=%0d ovr=%0d want 2/0", acks, ovrs);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [15:0] bits, lrs;
        int nbits, busy_cnt, acks, ovrs, ack_at, ovr_at, idle_at;
        @(negedge clk);
        s_trig = 1'b1; s_l = 4'hA; s_r = 4'h5;
        @(negedge clk);
        s_trig = 1'b0;
        repeat (11) @(negedge clk);
        checks++;
        if (s_busy !== 1'b1) begin
            failures++; $display("FAIL midframe_busy got=%b want=1", s_busy);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({s_ack, s_ovr, s_busy, s_bclk, s_lr, s_sd} !== 6'b0) begin
            failures++;
            $display("FAIL midframe_reset outs=%b want=000000", {s_ack, s_ovr, s_busy, s_bclk, s_lr, s_sd});
        end
        @(negedge clk);
        reset = 1'b0;
        watch_small(4'h3, 4'hC, 40, -1, 4'h0, 4'h0, bits, lrs, nbits, busy_cnt, acks, ovrs, ack_at, ovr_at, idle_at);
        checks++;
        if (nbits != 8 || bits[7:0] !== 8'h3C || lrs[7:0] !== 8'h0F) begin
            failures++; $display("FAIL post_reset_data nbits=%0d bits=%h lr=%h want 8/3c/0f", nbits, bits[7:0], lrs[7:0]);
        end
        checks++;
        if (acks != 1 || ack_at != 1 || busy_cnt != 32 || ovrs != 0) begin
            failures++;
            $display("FAIL post_reset_timing acks=%0d at=%0d busy=%0d ovr=%0d want 1/1/32/0", acks, ack_at, busy_cnt, ovrs);
        end
    endtask

    initial begin
        test_reset;
        test_single_frame;
        test_default_frames;
        test_overrun;
        test_back_to_back;
        test_reset_mid_frame;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
